vec_port_arbiter: RTL and testbench
===================================

VEC_PORT_ARBITER -- requirements
Module: vec_port_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (legal range 2..8).
REQ-002 SHALL have parameter AUM, default 8, width of one element in bits.
REQ-003 SHALL have parameter BUM, default 4, number of elements per beat.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester beat valid.
REQ-007 SHALL have port req_last  input  NREQ  per-requester last beat of burst.
REQ-008 SHALL have port req_data  input  [BUM-1:0][AUM-1:0] per requester, unpacked [NREQ]  beat payload.
REQ-009 SHALL have port req_ready  output  NREQ  per-requester beat accept.
REQ-010 SHALL have port out_valid  output  1  shared-port beat valid.
REQ-011 SHALL have port out_last  output  1  shared-port last beat.
REQ-012 SHALL have port out_data  output  [BUM-1:0][AUM-1:0]  shared-port payload.
REQ-013 SHALL have port out_src  output  $clog2(NREQ)  index of the requester that supplied the beat.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL implement states IDLE (no lock) and BURST (locked to index lock_idx).
REQ-016 SHALL, in IDLE, grant the first requester with req_valid set, searching round-robin from ptr+1 modulo NREQ.
REQ-017 SHALL drive req_ready[i] = granted(i) AND (NOT out_valid OR out_ready); all other req_ready bits 0.
REQ-018 SHALL treat a beat as accepted when req_valid[i] AND req_ready[i]; accepted data/last/index SHALL be registered onto out_* with 1-cycle latency.
REQ-019 SHALL set ptr to the granted index on the first accepted beat of every burst.
REQ-020 SHALL move IDLE->BURST on an accepted non-last first beat, and BURST->IDLE on an accepted last beat; a single-beat burst SHALL stay in IDLE.
REQ-021 SHALL, in BURST, grant only lock_idx, even if lock_idx deasserts req_valid mid-burst (no other requester is served).
REQ-022 SHALL hold out_valid, out_last, out_data, out_src stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid after out_ready=1 when no new beat is accepted that cycle.
REQ-024 SHALL sustain one beat per cycle with out_ready held 1, including back-to-back bursts from different requesters with no bubble.
REQ-025 SHALL never reorder or drop beats; beats of one burst SHALL be contiguous on the output.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, force state IDLE, ptr=NREQ-1 (requester 0 wins first), out_valid=0, out_last=0, out_data=0, out_src=0, req_ready=0.
REQ-027 SHALL abandon any in-flight burst on reset with no partial output afterwards.

Configuration
REQ-028 SHALL, with VEC_ARB_STATS_EN defined, add output grant_cnt, 16 bits per requester (unpacked [NREQ]), incremented on each burst start, saturating at 16'hFFFF, cleared on reset.
REQ-029 SHALL, without VEC_ARB_STATS_EN, omit grant_cnt and its counters entirely, with identical arbitration behaviour.

Structure
REQ-030 SHALL place the state typedef (arb_state_t: IDLE, BURST) and the counter width constant in shared package vec_arb_pkg.
REQ-031 SHALL implement the round-robin search in sub-module vec_rr_pick (inputs request vector, ptr; output one-hot grant, index, any).

Verification
REQ-032 SHALL check: reset, then req_valid=2'b11, single-beat bursts, out_ready=1 -> out_src sequence 0,1,0,1, one beat per cycle.
REQ-033 SHALL check: requester 0 sends 4-beat burst, requester 1 valid throughout -> out_src=0 for 4 beats, then 1; no interleave.
REQ-034 SHALL check: out_ready=0 for 3 cycles with out_valid=1, data 32'hA5A5_0001 -> out_* stable, req_ready=0 throughout.
REQ-035 SHALL check: requester 1 drops req_valid for 2 cycles mid-burst, requester 0 valid -> no output beats, burst resumes from 1.
REQ-036 SHALL check: rst_n=0 during beat 2 of a 4-beat burst -> next cycle out_valid=0, then requester 0 granted first.
REQ-037 SHALL check, with VEC_ARB_STATS_EN: 70000 single-beat grants to requester 0 -> grant_cnt[0]=16'hFFFF.

Source files
------------

// File: rtl/vec_arb_pkg.sv
// rtl/vec_arb_pkg.sv - shared types and constants for the vector port arbiter
//
// Purpose : arbiter state encoding, grant-counter width and a saturating
//           increment helper shared by vec_port_arbiter.
// Ports   : none (package).
// Option  : grant counters exist only when VEC_ARB_STATS_EN is defined.

package vec_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/vec_rr_pick.sv
// rtl/vec_rr_pick.sv - round-robin requester search
//
// Purpose : finds the first set request bit starting at ptr+1 and wrapping
//           modulo NREQ; ptr itself is checked last.
// Ports   : req   - request vector, one bit per requester
//           ptr   - index of the most recently served requester
//           grant - one-hot grant (all zero when no request)
//           idx   - binary index of the granted requester
//           any   - at least one request present

module vec_rr_pick #(
   parameter int NREQ  = 2,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any && req[(int'(ptr) + k) % NREQ]) begin
            any                               = 1'b1;
            grant[(int'(ptr) + k) % NREQ]     = 1'b1;
            idx                               = IDX_W'((int'(ptr) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/vec_port_arbiter.sv
// rtl/vec_port_arbiter.sv - burst-locking round-robin arbiter onto one vector port
//
// Purpose : NREQ requesters share one output port. A burst (beats up to and
//           including req_last) is never interleaved with another requester.
//           Accepted beats are registered onto out_* with one cycle latency
//           and full one-beat-per-cycle throughput.
// Ports   : clk, rst_n          - clock, synchronous active-low reset
//           req_valid/req_last - per-requester beat valid / last beat of burst
//           req_data[NREQ]     - per-requester payload, BUM elements of AUM bits
//           req_ready          - per-requester beat accept
//           out_valid/out_last/out_data/out_src - shared port beat, src index
//           out_ready          - downstream accept
//           grant_cnt[NREQ]    - burst-start counters (VEC_ARB_STATS_EN only)
// Option  : define VEC_ARB_STATS_EN to add the saturating grant counters.

module vec_port_arbiter
   import vec_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AUM  = 8,
   parameter int BUM  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ-1:0]               req_last,
   input  logic [BUM-1:0][AUM-1:0]       req_data [NREQ],
   output logic [NREQ-1:0]               req_ready,
   output logic                          out_valid,
   output logic                          out_last,
   output logic [BUM-1:0][AUM-1:0]       out_data,
   output logic [$clog2(NREQ)-1:0]       out_src,
   input  logic                          out_ready
`ifdef VEC_ARB_STATS_EN
   ,output logic [CNT_W-1:0]             grant_cnt [NREQ]
`endif
);

   localparam int IDX_W = $clog2(NREQ);

   arb_state_t              state;
   logic [IDX_W-1:0]        ptr;
   logic [IDX_W-1:0]        lock_idx;

   logic [NREQ-1:0]         pick_grant;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_any;

   logic [NREQ-1:0]         grant;
   logic [IDX_W-1:0]        gnt_idx;
   logic                    can_take;
   logic                    accept;
   logic [BUM-1:0][AUM-1:0] sel_data;
   logic                    sel_last;

   vec_rr_pick #(
      .NREQ (NREQ),
      .IDX_W(IDX_W)
   ) u_pick (
      .req  (req_valid),
      .ptr  (ptr),
      .grant(pick_grant),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // While locked, the grant stays on lock_idx even if it drops req_valid,
   // so nobody else can slip into the middle of its burst.
   always_comb begin
      grant   = '0;
      gnt_idx = lock_idx;
      if (state == BURST) begin
         for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == lock_idx) begin
               grant[i] = 1'b1;
            end
         end
      end else if (pick_any) begin
         grant   = pick_grant;
         gnt_idx = pick_idx;
      end
   end

   // The output register can take a new beat when empty or draining this cycle.
   assign can_take  = !out_valid || out_ready;
   assign req_ready = (rst_n && can_take) ? grant : '0;
   assign accept    = |(req_valid & req_ready);

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_data = req_data[i];
            sel_last = req_last[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= IDX_W'(NREQ - 1);
         lock_idx  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_last  <= sel_last;
            out_data  <= sel_data;
            out_src   <= gnt_idx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  ptr      <= gnt_idx;
                  lock_idx <= gnt_idx;
                  if (!sel_last) begin
                     state <= BURST;
                  end
               end
            end
            BURST: begin
               if (accept && sel_last) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VEC_ARB_STATS_EN
   // A burst starts on any beat accepted while unlocked.
   logic burst_start;
   assign burst_start = accept && (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i] <= '0;
         end
      end else if (burst_start) begin
         for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == gnt_idx) begin
               grant_cnt[i] <= sat_inc(grant_cnt[i]);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_vec_port_arbiter.sv
// tb/tb_vec_port_arbiter.sv - scoreboard bench for vec_port_arbiter

module tb_vec_port_arbiter;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [3:0]  gap;
   } beat_t;

   typedef struct packed {
      logic        src;
      logic        last;
      logic [31:0] data;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_last;
   logic [3:0][7:0]  req_data [2];
   logic [1:0]       req_ready;
   logic             out_valid;
   logic             out_last;
   logic [3:0][7:0]  out_data;
   logic             out_src;
   logic             out_ready;
`ifdef VEC_ARB_STATS_EN
   logic [15:0]      grant_cnt [2];
`endif

   int     checks;
   int     errors;
   int     cyc;
   int     hs_cnt;
   int     first_hs;
   int     last_hs;
   bit     mon_en;
   exp_t   exp_q[$];
   beat_t  drv_q[2][$];
   int     wait_cnt[2];
   bit     loaded[2];
   logic [1:0] acc;

   vec_port_arbiter #(.NREQ(2), .AUM(8), .BUM(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_last (req_last),
      .req_data (req_data),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_last (out_last),
      .out_data (out_data),
      .out_src  (out_src),
      .out_ready(out_ready)
`ifdef VEC_ARB_STATS_EN
      ,.grant_cnt(grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester driver: presents queued beats, honours per-beat idle gaps,
   // retires a beat once its handshake was seen just before the edge.
   initial begin
      acc       = '0;
      req_valid = '0;
      req_last  = '0;
      req_data[0] = '0;
      req_data[1] = '0;
      for (int i = 0; i < 2; i++) begin
         wait_cnt[i] = 0;
         loaded[i]   = 1'b0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (acc[i] && drv_q[i].size() > 0) begin
               drv_q[i].delete(0);
               loaded[i] = 1'b0;
            end
            if (!loaded[i] && drv_q[i].size() > 0) begin
               wait_cnt[i] = int'(drv_q[i][0].gap);
               loaded[i]   = 1'b1;
            end
            if (loaded[i] && wait_cnt[i] == 0) begin
               req_valid[i] = 1'b1;
               req_last[i]  = drv_q[i][0].last;
               req_data[i]  = drv_q[i][0].data;
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
               req_data[i]  = '0;
               if (loaded[i]) wait_cnt[i] = wait_cnt[i] - 1;
            end
         end
         #7;
         acc = req_valid & req_ready;
      end
   end

   // Output monitor: pops the scoreboard on every output handshake.
   initial begin
      exp_t e;
      cyc = 0;
      forever begin
         @(posedge clk);
         #8;
         cyc++;
         if (mon_en && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat got src=%0d last=%0d data=%h", out_src, out_last, out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_src !== e.src || out_last !== e.last || out_data !== e.data) begin
                  errors++;
                  $display("FAIL beat got src=%0d last=%0d data=%h exp src=%0d last=%0d data=%h",
                           out_src, out_last, out_data, e.src, e.last, e.data);
               end
            end
            if (hs_cnt == 0) first_hs = cyc;
            last_hs = cyc;
            hs_cnt++;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic send(input int r, input logic [31:0] d, input logic l, input logic [3:0] g);
      beat_t b;
      b.data = d;
      b.last = l;
      b.gap  = g;
      drv_q[r].push_back(b);
   endtask

   task automatic expect_beat(input logic s, input logic l, input logic [31:0] d);
      exp_t e;
      e.src  = s;
      e.last = l;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || drv_q[0].size() != 0 || drv_q[1].size() != 0 || out_valid)
             && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout got pending=%0d exp pending=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int n;
      checks    = 0;
      errors    = 0;
      hs_cnt    = 0;
      first_hs  = 0;
      last_hs   = 0;
      mon_en    = 1'b1;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_out_data",  out_data,       32'd0);
      chk("rst_out_src",   32'(out_src),   32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-beat bursts from both: strict alternation 0,1,0,1 with no bubble.
      hs_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         send(0, 32'h1000_0000 + 32'(k), 1'b1, 4'd0);
         send(1, 32'h1100_0000 + 32'(k), 1'b1, 4'd0);
         expect_beat(1'b0, 1'b1, 32'h1000_0000 + 32'(k));
         expect_beat(1'b1, 1'b1, 32'h1100_0000 + 32'(k));
      end
      drain("alt", 100);
      chk("alt_count", 32'(hs_cnt), 32'd8);
      chk("alt_span",  32'(last_hs - first_hs), 32'd7);

      // 4-beat burst from 0 while 1 waits: no interleave, then 1 back-to-back.
      hs_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         send(0, 32'h2000_0000 + 32'(k), (k == 3), 4'd0);
         expect_beat(1'b0, (k == 3), 32'h2000_0000 + 32'(k));
      end
      send(1, 32'h2100_0000, 1'b1, 4'd0);
      send(1, 32'h2100_0001, 1'b1, 4'd0);
      expect_beat(1'b1, 1'b1, 32'h2100_0000);
      expect_beat(1'b1, 1'b1, 32'h2100_0001);
      drain("burst", 100);
      chk("burst_count", 32'(hs_cnt), 32'd6);
      chk("burst_span",  32'(last_hs - first_hs), 32'd5);

      // Backpressure: out_* frozen and no requester ready while stalled.
      out_ready = 1'b0;
      send(0, 32'hA5A5_0001, 1'b1, 4'd0);
      send(1, 32'h3100_0000, 1'b1, 4'd0);
      expect_beat(1'b0, 1'b1, 32'hA5A5_0001);
      expect_beat(1'b1, 1'b1, 32'h3100_0000);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int c = 0; c < 3; c++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data",  out_data,       32'hA5A5_0001);
         chk("stall_src",   32'(out_src),   32'd0);
         chk("stall_last",  32'(out_last),  32'd1);
         chk("stall_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      drain("stall", 100);

      // Requester 1 goes idle 2 cycles mid-burst; 0 must wait for its last beat.
      hs_cnt = 0;
      send(1, 32'h4100_0000, 1'b0, 4'd0);
      send(1, 32'h4100_0001, 1'b0, 4'd2);
      send(1, 32'h4100_0002, 1'b1, 4'd0);
      send(0, 32'h4000_0000, 1'b1, 4'd2);
      expect_beat(1'b1, 1'b0, 32'h4100_0000);
      expect_beat(1'b1, 1'b0, 32'h4100_0001);
      expect_beat(1'b1, 1'b1, 32'h4100_0002);
      expect_beat(1'b0, 1'b1, 32'h4000_0000);
      drain("gap", 100);
      chk("gap_count", 32'(hs_cnt), 32'd4);
      chk("gap_span",  32'(last_hs - first_hs), 32'd5);

      // Reset in the middle of a burst from 0: nothing leaks out afterwards.
      mon_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send(0, 32'h5000_0000 + 32'(k), (k == 3), 4'd0);
      end
      n = 0;
      while (!(out_valid && out_data == 32'h5000_0001) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_reached", 32'(out_data), 32'h5000_0001);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drv_q[i].delete();
         loaded[i] = 1'b0;
      end
      @(negedge clk);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      mon_en = 1'b1;
      send(1, 32'h5100_0000, 1'b1, 4'd0);
      send(0, 32'h5000_0010, 1'b1, 4'd0);
      expect_beat(1'b0, 1'b1, 32'h5000_0010);
      expect_beat(1'b1, 1'b1, 32'h5100_0000);
      drain("after_rst", 100);

`ifdef VEC_ARB_STATS_EN
      chk("cnt0_after_rst", 32'(grant_cnt[0]), 32'd1);
      chk("cnt1_after_rst", 32'(grant_cnt[1]), 32'd1);
      for (int k = 0; k < 70000; k++) begin
         send(0, 32'(k), 1'b1, 4'd0);
         expect_beat(1'b0, 1'b1, 32'(k));
      end
      drain("stats", 75000);
      chk("cnt0_sat", 32'(grant_cnt[0]), 32'h0000_FFFF);
      chk("cnt1_hold", 32'(grant_cnt[1]), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
